execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Parameterised RV32I-family execute stage with valid/ready handshakes on both sides, replacing the always-loading execute register.
- Computes ALU results, resolves conditional branches and jumps, and issues a one-cycle PC redirect to fetch.
- Holds one result in an output register that stalls under back-pressure; a flush input squashes in-flight work.
- An optional iterative multiplier adds multi-cycle operations.

Parameters:
WIDTH, 32, datapath width in bits (power of 2, >= 8)
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  squash output register, redirect and any multiply in progress
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  WIDTH  instruction PC
in_rs1  in  WIDTH  source operand 1
in_rs2  in  WIDTH  source operand 2
in_imm  in  WIDTH  pre-decoded immediate
in_rd  in  RD_W  destination index
in_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL
in_a_sel  in  1  ALU A: 0 rs1, 1 pc
in_b_sel  in  1  ALU B: 0 rs2, 1 imm
in_br  in  1  conditional branch
in_jump  in  1  JAL/JALR
in_cmpop  in  3  funct3 encoding: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
out_valid  out  1  result register valid
out_ready  in  1  downstream accepts
out_result  out  WIDTH  writeback value
out_rd  out  RD_W  destination index
out_pc  out  WIDTH  PC of the result
redirect_valid  out  1  one-cycle redirect pulse
redirect_pc  out  WIDTH  redirect target

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - out_valid=0, redirect_valid=0.
  - out_result, out_rd, out_pc and redirect_pc are all 0.
  - FSM returns to IDLE.
- in_ready = !rst && !flush && state==IDLE && (!out_valid || out_ready).
- Acceptance: in_valid && in_ready at a clock edge.
- Single-cycle ops: the result register loads at the accept edge. out_valid is high in the following cycle (latency 1). Back-to-back throughput is 1 per cycle when out_ready=1.
- Output register:
  - out_valid clears when out_ready=1 and no new load occurs.
  - Contents stay stable while out_valid && !out_ready.
- Arithmetic:
  - All ops wrap modulo 2^WIDTH.
  - Shift amount is B[log2(WIDTH)-1:0].
  - SRA is arithmetic.
  - SLT is signed and SLTU unsigned; both return a zero-extended 0/1.
  - Opcodes 11-15 produce 0.
- Branch (in_br=1):
  - Compares in_rs1 against in_rs2 per in_cmpop; undefined cmpop encodings mean not taken.
  - The ALU result (decoder sets pc+imm) is the target.
  - out_result=0.
  - If taken, redirect_valid=1 for exactly one cycle, coincident with the first cycle of out_valid, and redirect_pc=target.
- Jump (in_jump=1):
  - Always redirects.
  - redirect_pc = ALU result with bit 0 cleared.
  - out_result = in_pc+4.
  - in_jump has priority over in_br.
- redirect_valid never repeats while the output stalls.
- Flush (synchronous):
  - Next cycle: out_valid=0, redirect_valid=0, FSM to IDLE.
  - No acceptance occurs in the flush cycle.
- rst has priority over flush.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: accepting MUL goes to MUL.
  - MUL: after the last iteration, goes to HOLD.
  - HOLD: loads the output register when (!out_valid || out_ready), then returns to IDLE.
  - Without the optional feature, only IDLE is reachable.

Optional Feature:
EXECUTE_MUL_EN
- Defined:
  - op 10 is an iterative shift-add multiply returning the low WIDTH bits.
  - One bit is processed per cycle for WIDTH cycles in state MUL; in_ready=0 while busy.
  - With out_ready=1, out_valid rises WIDTH+1 cycles after the accept edge.
  - rs1/rs2 are sampled at acceptance.
  - Flush or rst aborts the operation with no output.
- Undefined:
  - op 10 behaves as opcodes 11-15 (result 0, latency 1).
  - No multiplier logic or MUL/HOLD states are built.

Test Plan:
- Reset then ADD rs1=0x7FFFFFFF, rs2=1, b_sel=0 -> next cycle out_valid=1, out_result=0x80000000, redirect_valid=0.
- SRA rs1=0x80000000, rs2=0x24 -> out_result=0xF8000000 (shift 4); SLT rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU -> 0.
- BLT pc=0x100, imm=0x20, rs1=-1, rs2=0, a_sel=1, b_sel=1 -> one-cycle redirect_valid, redirect_pc=0x120, out_result=0. Same with BGE -> no redirect.
- JALR rs1=0x203, imm=4, rd=1, pc=0x40 -> redirect_pc=0x206, out_result=0x44. Hold out_ready=0 for 5 cycles -> outputs stable, redirect pulsed once, in_ready=0.
- Flush asserted the cycle after a taken branch is accepted -> out_valid=0 and redirect_valid=0 next cycle; in_valid in the flush cycle is not accepted.
- With EXECUTE_MUL_EN: MUL 0xFFFF x 0x10001 -> out_valid after 33 cycles, result 0xFFFFFFFF. Repeat with rst mid-multiply -> no output, in_ready=1 after reset.

Source files
------------

// File: rtl/execute_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : RV32I-family execute stage with valid/ready handshakes, branch
//            resolution, one-cycle PC redirect and an optional iterative
//            multiplier enabled by the EXECUTE_MUL_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [3:0]       in_op,
  input  logic             in_a_sel,
  input  logic             in_b_sel,
  input  logic             in_br,
  input  logic             in_jump,
  input  logic [2:0]       in_cmpop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic [WIDTH-1:0] out_pc,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);

  localparam int               c_SHW  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_FOUR = WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [RD_W-1:0]  r_out_rd;
  logic [WIDTH-1:0] r_out_pc;
  logic             r_redir_valid;
  logic [WIDTH-1:0] r_redir_pc;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [c_SHW-1:0] w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic             w_cmp;
  logic             w_taken;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_rpc;
  logic             w_accept;
  logic             w_room;
  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;
  logic [RD_W-1:0]  w_mul_rd;
  logic [WIDTH-1:0] w_mul_pc;
  logic             w_load_alu;
  logic             w_load_mul;

  assign w_room     = !r_out_valid || out_ready;
  assign in_ready   = !rst && !flush && (r_state == S_IDLE) && w_room;
  assign w_accept   = in_valid && in_ready;
  assign w_load_alu = w_accept && !w_is_mul;
  assign w_load_mul = (r_state == S_HOLD) && w_room && !flush;

  assign w_a     = in_a_sel ? in_pc  : in_rs1;
  assign w_b     = in_b_sel ? in_imm : in_rs2;
  assign w_shamt = w_b[c_SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (in_op)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a << w_shamt;
      4'd3:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      4'd4:    w_alu = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      4'd5:    w_alu = w_a ^ w_b;
      4'd6:    w_alu = w_a >> w_shamt;
      4'd7:    w_alu = $signed(w_a) >>> w_shamt;
      4'd8:    w_alu = w_a | w_b;
      4'd9:    w_alu = w_a & w_b;
      default: w_alu = '0;
    endcase
  end

  // Branch comparison always uses the register operands, never the ALU inputs.
  always_comb begin
    w_cmp = 1'b0;
    case (in_cmpop)
      3'b000:  w_cmp = (in_rs1 == in_rs2);
      3'b001:  w_cmp = (in_rs1 != in_rs2);
      3'b100:  w_cmp = ($signed(in_rs1) < $signed(in_rs2));
      3'b101:  w_cmp = !($signed(in_rs1) < $signed(in_rs2));
      3'b110:  w_cmp = (in_rs1 < in_rs2);
      3'b111:  w_cmp = !(in_rs1 < in_rs2);
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_taken = in_jump || (in_br && w_cmp);
  assign w_res   = in_jump ? (in_pc + c_FOUR) : (in_br ? '0 : w_alu);
  assign w_rpc   = in_jump ? {w_alu[WIDTH-1:1], 1'b0} : w_alu;

`ifdef EXECUTE_MUL_EN
  localparam logic [c_SHW-1:0] c_LAST    = c_SHW'(WIDTH - 1);
  localparam logic [c_SHW-1:0] c_CNT_ONE = c_SHW'(1);

  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  logic [WIDTH-1:0] r_mul_acc;
  logic [c_SHW-1:0] r_mul_cnt;
  logic [RD_W-1:0]  r_mul_rd;
  logic [WIDTH-1:0] r_mul_pc;

  assign w_is_mul   = (in_op == 4'd10) && !in_br && !in_jump;
  assign w_mul_done = (r_mul_cnt == c_LAST);
  assign w_mul_res  = r_mul_acc;
  assign w_mul_rd   = r_mul_rd;
  assign w_mul_pc   = r_mul_pc;

  // Shift-add: one multiplier bit per cycle, low WIDTH bits of the product kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_cnt <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a   <= in_rs1;
      r_mul_b   <= in_rs2;
      r_mul_acc <= '0;
      r_mul_cnt <= '0;
      r_mul_rd  <= in_rd;
      r_mul_pc  <= in_pc;
    end else if (r_state == S_MUL) begin
      if (r_mul_b[0]) begin
        r_mul_acc <= r_mul_acc + r_mul_a;
      end
      r_mul_a   <= r_mul_a << 1;
      r_mul_b   <= r_mul_b >> 1;
      r_mul_cnt <= r_mul_cnt + c_CNT_ONE;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_rd   = '0;
  assign w_mul_pc   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
        S_MUL:   if (w_mul_done) w_state_nxt = S_HOLD;
        S_HOLD:  if (w_room) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Redirect is a pulse tied to the load, so a stalled result never re-fires it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_rd      <= '0;
      r_out_pc      <= '0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
      r_redir_valid <= 1'b0;
    end else begin
      r_redir_valid <= 1'b0;
      if (w_load_alu) begin
        r_out_valid   <= 1'b1;
        r_out_result  <= w_res;
        r_out_rd      <= in_rd;
        r_out_pc      <= in_pc;
        r_redir_valid <= w_taken;
        if (w_taken) begin
          r_redir_pc <= w_rpc;
        end
      end else if (w_load_mul) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_mul_res;
        r_out_rd     <= w_mul_rd;
        r_out_pc     <= w_mul_pc;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_rd         = r_out_rd;
  assign out_pc         = r_out_pc;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for execute_stage: the driver queues expected results at
// acceptance, an independent monitor pops and compares each output beat.
module tb_execute_stage;

  localparam int WIDTH = 32;
  localparam int RD_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic [3:0]        in_op = '0;
  logic              in_a_sel = 1'b0, in_b_sel = 1'b0, in_br = 1'b0, in_jump = 1'b0;
  logic [2:0]        in_cmpop = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_result, out_pc, redirect_pc;
  logic [RD_W-1:0]   out_rd;
  logic              redirect_valid;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_rd(in_rd), .in_op(in_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_br(in_br), .in_jump(in_jump), .in_cmpop(in_cmpop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t    sb[$];
  int      checks = 0;
  int      errors = 0;
  logic    first_beat = 1'b1;
  longint  t_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every visible output beat against the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual result=0x%08h rd=%0d expected no output", out_result, out_rd);
        end else begin
          chk("out_result", out_result, sb[0].res);
          chk("out_rd", 32'(out_rd), 32'(sb[0].rd));
          chk("out_pc", out_pc, sb[0].pc);
          if (first_beat) begin
            chk("redirect_valid", 32'(redirect_valid), 32'(sb[0].redir));
            if (sb[0].redir) chk("redirect_pc", redirect_pc, sb[0].rpc);
          end else begin
            chk("redirect_repeat", 32'(redirect_valid), 32'd0);
          end
          if (out_ready) void'(sb.pop_front());
        end
        first_beat = out_ready;
      end else begin
        chk("redirect_idle", 32'(redirect_valid), 32'd0);
        first_beat = 1'b1;
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd, input logic [3:0] op,
                       input logic asel, input logic bsel, input logic br, input logic jmp,
                       input logic [2:0] cmp, input logic expect_out,
                       input logic [31:0] eres, input logic eredir, input logic [31:0] erpc);
    exp_t e;
    logic accepted;
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd; in_op = op;
    in_a_sel = asel; in_b_sel = bsel; in_br = br; in_jump = jmp; in_cmpop = cmp;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (expect_out) begin
          e.res = eres; e.rd = rd; e.pc = pc; e.redir = eredir; e.rpc = erpc;
          sb.push_back(e);
        end
      end
      @(posedge clk);
      if (accepted) t_acc = longint'($time);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual in_ready=0 expected acceptance within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // ALU ops back-to-back: pc, rs1, rs2, imm, rd, op, asel, bsel, br, jmp, cmp
    issue(32'h10, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd3, 4'd0, 0, 0, 0, 0, 3'b000, 1, 32'h8000_0000, 0, 0);
    issue(32'h14, 32'h5, 32'h7, 32'h0, 5'd4, 4'd1, 0, 0, 0, 0, 3'b000, 1, 32'hFFFF_FFFE, 0, 0);
    issue(32'h18, 32'h1, 32'h21, 32'h0, 5'd5, 4'd2, 0, 0, 0, 0, 3'b000, 1, 32'h2, 0, 0);
    issue(32'h1C, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd6, 4'd3, 0, 0, 0, 0, 3'b000, 1, 32'h1, 0, 0);
    issue(32'h20, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd7, 4'd4, 0, 0, 0, 0, 3'b000, 1, 32'h0, 0, 0);
    issue(32'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'd8, 4'd5, 0, 0, 0, 0, 3'b000, 1, 32'h0FF0_0FF0, 0, 0);
    issue(32'h28, 32'h8000_0000, 32'h24, 32'h0, 5'd9, 4'd6, 0, 0, 0, 0, 3'b000, 1, 32'h0800_0000, 0, 0);
    issue(32'h2C, 32'h8000_0000, 32'h24, 32'h0, 5'd10, 4'd7, 0, 0, 0, 0, 3'b000, 1, 32'hF800_0000, 0, 0);
    issue(32'h30, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0, 5'd11, 4'd8, 0, 0, 0, 0, 3'b000, 1, 32'hFFFF_F0F0, 0, 0);
    issue(32'h34, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'd12, 4'd9, 0, 0, 0, 0, 3'b000, 1, 32'hF000_F000, 0, 0);
    issue(32'h38, 32'h1234_5678, 32'h1, 32'h0, 5'd13, 4'd12, 0, 0, 0, 0, 3'b000, 1, 32'h0, 0, 0);
    issue(32'h3C, 32'h10, 32'h0, 32'hFFFF_FFFF, 5'd14, 4'd0, 0, 1, 0, 0, 3'b000, 1, 32'hF, 0, 0);
`ifndef EXECUTE_MUL_EN
    issue(32'h40, 32'hFFFF, 32'h10001, 32'h0, 5'd15, 4'd10, 0, 0, 0, 0, 3'b000, 1, 32'h0, 0, 0);
`endif

    // Branches: BLT taken, BGE not, BNE equal, undefined cmpop, BGEU not, BLTU taken
    issue(32'h100, 32'hFFFF_FFFF, 32'h0, 32'h20, 5'd0, 4'd0, 1, 1, 1, 0, 3'b100, 1, 32'h0, 1, 32'h120);
    issue(32'h104, 32'hFFFF_FFFF, 32'h0, 32'h20, 5'd0, 4'd0, 1, 1, 1, 0, 3'b101, 1, 32'h0, 0, 0);
    issue(32'h108, 32'h3, 32'h3, 32'h20, 5'd0, 4'd0, 1, 1, 1, 0, 3'b001, 1, 32'h0, 0, 0);
    issue(32'h10C, 32'h3, 32'h3, 32'h20, 5'd0, 4'd0, 1, 1, 1, 0, 3'b010, 1, 32'h0, 0, 0);
    issue(32'h110, 32'h0, 32'hFFFF_FFFF, 32'h20, 5'd0, 4'd0, 1, 1, 1, 0, 3'b111, 1, 32'h0, 0, 0);
    issue(32'h80, 32'h0, 32'hFFFF_FFFF, 32'h10, 5'd0, 4'd0, 1, 1, 1, 0, 3'b110, 1, 32'h0, 1, 32'h90);
    // JAL with in_br also set and a false compare: jump wins
    issue(32'h500, 32'h1, 32'h2, 32'h101, 5'd2, 4'd0, 1, 1, 1, 1, 3'b000, 1, 32'h504, 1, 32'h600);
    idle(3);

    // JALR under 5 cycles of back-pressure
    out_ready = 1'b0;
    issue(32'h40, 32'h203, 32'h0, 32'h4, 5'd1, 4'd0, 0, 1, 0, 1, 3'b000, 1, 32'h44, 1, 32'h206);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(2);

    // Flush the cycle after a taken branch is accepted; concurrent input must be dropped
    issue(32'h200, 32'h5, 32'h5, 32'h8, 5'd0, 4'd0, 1, 1, 1, 0, 3'b000, 1, 32'h0, 1, 32'h208);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_br = 1'b0; in_jump = 1'b0; in_rd = 5'd9;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    chk("post_flush_redirect", 32'(redirect_valid), 32'd0);
    idle(2);

`ifdef EXECUTE_MUL_EN
    begin
      int lat;
      logic seen;
      lat = -1;
      issue(32'h300, 32'hFFFF, 32'h10001, 32'h0, 5'd7, 4'd10, 0, 0, 0, 0, 3'b000, 1, 32'hFFFF_FFFF, 0, 0);
      @(negedge clk);
      chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 100; i++) begin
        if (out_valid) begin
          lat = int'((longint'($time) - t_acc - 5) / 10);
          break;
        end
        @(negedge clk);
      end
      chk("mul_latency", 32'(lat), 32'd33);
      idle(2);

      issue(32'h304, 32'hFFFF, 32'h10001, 32'h0, 5'd8, 4'd10, 0, 0, 0, 0, 3'b000, 0, 32'h0, 0, 0);
      idle(10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mul_abort_in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("mul_abort_no_output", 32'(seen), 32'd0);
    end
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    idle(1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
